// File: rtl/turbo_frame_ctrl.sv
// turbo_frame_ctrl: turbo encoder frame sequencer with handshake intake, armed interleaver wait,
// LSB-first bit streaming to both constituent encoders and trellis termination.
module turbo_frame_ctrl #(
    parameter int FRAME_BITS = 8,
    parameter int TAIL_LEN = 3,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] in_sel,
    output logic [7:0] il_data,
    output logic [1:0] il_sel,
    input  logic       il_bit_start,
    input  logic [7:0] il_out,
    output logic       enc_en,
    output logic       enc_sys,
    output logic       enc_il,
    output logic       enc_term,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout
);
    localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
    localparam int TW = TAIL_LEN > 1 ? $clog2(TAIL_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_IL, ENCODE, TAIL, DONE} state_t;
    state_t state;
    logic [7:0] data_reg;
    logic [7:0] il_reg;
    logic [BW-1:0] bit_idx;
    logic [BW-1:0] bit_nxt;
    logic [TW-1:0] tail_cnt;
    logic [WW-1:0] wait_cnt;
    logic arm;
    assign bit_nxt = bit_idx + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b0;
            il_data <= '0;
            il_sel <= '0;
            enc_en <= 1'b0;
            enc_sys <= 1'b0;
            enc_il <= 1'b0;
            enc_term <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            err_timeout <= 1'b0;
            data_reg <= '0;
            il_reg <= '0;
            bit_idx <= '0;
            tail_cnt <= '0;
            wait_cnt <= '0;
            arm <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        data_reg <= in_data;
                        il_data <= in_data;
                        il_sel <= in_sel;
                        in_ready <= 1'b0;
                        busy <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    wait_cnt <= '0;
                    arm <= 1'b0;
                    state <= WAIT_IL;
                end
                WAIT_IL: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // a high bit_start only counts once a low sample has been seen this frame
                    if (il_bit_start && arm) begin
                        il_reg <= il_out;
                        bit_idx <= '0;
                        enc_en <= 1'b1;
                        enc_sys <= data_reg[0];
                        enc_il <= il_out[0];
                        state <= ENCODE;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy <= 1'b0;
                        in_ready <= 1'b1;
                        state <= IDLE;
                    end else if (!il_bit_start) begin
                        arm <= 1'b1;
                    end
                end
                ENCODE: begin
                    if (bit_idx == BW'(FRAME_BITS - 1)) begin
                        tail_cnt <= '0;
                        enc_term <= 1'b1;
                        enc_sys <= 1'b0;
                        enc_il <= 1'b0;
                        state <= TAIL;
                    end else begin
                        bit_idx <= bit_nxt;
                        enc_sys <= data_reg[bit_nxt];
                        enc_il <= il_reg[bit_nxt];
                    end
                end
                TAIL: begin
                    if (tail_cnt == TW'(TAIL_LEN - 1)) begin
                        enc_en <= 1'b0;
                        enc_term <= 1'b0;
                        frame_done <= 1'b1;
                        state <= DONE;
                    end else begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    in_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// tb_turbo_frame_ctrl: queue-based reference model compared every cycle, directed plan scenarios
// with literal expectations, then randomized traffic including timeouts and mid-frame resets.
module tb_turbo_frame_ctrl;
    localparam int FB = 8;
    localparam int TL = 3;
    localparam int TO = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic il_bit_start = 1'b0;
    logic [7:0] il_out = '0;
    logic in_ready, enc_en, enc_sys, enc_il, enc_term, busy, frame_done, err_timeout;
    logic [7:0] il_data;
    logic [1:0] il_sel;

    turbo_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .il_data(il_data), .il_sel(il_sel),
        .il_bit_start(il_bit_start), .il_out(il_out), .enc_en(enc_en), .enc_sys(enc_sys),
        .enc_il(enc_il), .enc_term(enc_term), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // expected outputs after each edge
    logic e_ready = 0, e_en = 0, e_sys = 0, e_il = 0, e_term = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [7:0] e_il_data = '0;
    logic [1:0] e_il_sel = '0;
    int mode = 0;
    int waited = 0;
    bit armed = 0;
    logic [7:0] d_frame = '0;
    logic [4:0] plan[$];

    // frame = idle -> one load cycle -> wait for armed bit_start -> play back a precomputed schedule
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            {e_ready, e_en, e_sys, e_il, e_term, e_busy, e_done, e_err} = '0;
            e_il_data = '0;
            e_il_sel = '0;
            mode = 0;
            plan.delete();
        end else begin
            e_done = 0;
            e_err = 0;
            if (mode == 0) begin
                if (in_valid && e_ready) begin
                    e_il_data = in_data;
                    e_il_sel = in_sel;
                    d_frame = in_data;
                    e_ready = 0;
                    e_busy = 1;
                    mode = 1;
                end else e_ready = 1;
            end else if (mode == 1) begin
                mode = 2;
                waited = 0;
                armed = 0;
            end else if (mode == 2) begin
                waited++;
                if (il_bit_start && armed) begin
                    for (int i = 0; i < FB; i++) plan.push_back({1'b1, d_frame[i], il_out[i], 1'b0, 1'b0});
                    for (int i = 0; i < TL; i++) plan.push_back(5'b10010);
                    plan.push_back(5'b00001);
                    {e_en, e_sys, e_il, e_term, e_done} = plan.pop_front();
                    mode = 3;
                end else if (waited == TO) begin
                    e_err = 1;
                    e_busy = 0;
                    e_ready = 1;
                    mode = 0;
                end else if (!il_bit_start) armed = 1;
            end else begin
                if (plan.size() > 0) {e_en, e_sys, e_il, e_term, e_done} = plan.pop_front();
                else begin
                    e_busy = 0;
                    e_ready = 1;
                    mode = 0;
                end
            end
        end
    end

    logic [7:0] sys_col = '0, il_col = '0;
    int term_cnt = 0, en_cnt = 0, busy_cnt = 0, cyc = 0;
    logic [21:0] got_v, exp_v;

    initial forever begin
        @(negedge clk);
        got_v = {in_ready, il_data, il_sel, enc_en, enc_sys, enc_il, enc_term, busy, frame_done, err_timeout};
        exp_v = {e_ready, e_il_data, e_il_sel, e_en, e_sys, e_il, e_term, e_busy, e_done, e_err};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d dut=%b model=%b", cyc, got_v, exp_v);
        end
        if (enc_en && !enc_term) begin
            sys_col = {enc_sys, sys_col[7:1]};
            il_col = {enc_il, il_col[7:1]};
        end
        if (enc_term) term_cnt++;
        if (enc_en) en_cnt++;
        if (busy) busy_cnt++;
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s);
        in_valid = 1;
        in_data = d;
        in_sel = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_ready", {31'b0, in_ready}, 1);
        tick();
        in_valid = 0;
        in_data = 8'($urandom);
        in_sel = 2'($urandom);
    endtask

    task automatic wait_end(input int budget, output int r);
        r = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin r = 1; break; end
            if (err_timeout) begin r = 2; break; end
        end
        if (r == 0) chk("frame_end_timeout", 0, 1);
    endtask

    task automatic quick_capture(input logic [7:0] o);
        il_bit_start = 0;
        tick();
        tick();
        il_bit_start = 1;
        il_out = o;
        tick();
        il_bit_start = 0;
    endtask

    int r, t0, e0, b0, rm;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("ready_before_edge", {31'b0, in_ready}, 0);
        @(negedge clk);
        chk("ready_after_edge", {31'b0, in_ready}, 1);
        chk("idle_busy", {31'b0, busy}, 0);
        // basic frame A5 / block interleaver
        tick();
        il_bit_start = 0;
        send(8'hA5, 2'b11);
        t0 = term_cnt;
        e0 = en_cnt;
        tick();
        tick();
        tick();
        il_bit_start = 1;
        il_out = 8'h3C;
        tick();
        il_bit_start = 0;
        wait_end(40, r);
        chk("a5_done", r, 1);
        chk("a5_sys", sys_col, 8'hA5);
        chk("a5_il", il_col, 8'h3C);
        chk("a5_il_data", il_data, 8'hA5);
        chk("a5_il_sel", il_sel, 2'b11);
        chk("a5_tail", term_cnt - t0, 3);
        chk("a5_en_len", en_cnt - e0, 11);
        @(negedge clk);
        chk("a5_ready_next", {31'b0, in_ready}, 1);
        // stale-high bit_start never arms: timeout
        tick();
        il_bit_start = 1;
        send(8'h77, 2'b01);
        b0 = busy_cnt;
        e0 = en_cnt;
        wait_end(200, r);
        chk("to_err", r, 2);
        chk("to_busy_cycles", busy_cnt - b0, 65);
        chk("to_no_en", en_cnt - e0, 0);
        chk("to_idle", {31'b0, busy}, 0);
        // 1,1,0,1 pattern captures only on the 4th sample
        tick();
        il_bit_start = 1;
        send(8'h5C, 2'b10);
        il_out = 8'h00;
        tick();
        tick();
        tick();
        il_bit_start = 0;
        tick();
        il_bit_start = 1;
        il_out = 8'hFF;
        tick();
        il_bit_start = 0;
        il_out = 8'h00;
        wait_end(40, r);
        chk("arm_done", r, 1);
        chk("arm_il", il_col, 8'hFF);
        chk("arm_sys", sys_col, 8'h5C);
        // reset during ENCODE bit 4
        tick();
        send(8'hC3, 2'b10);
        quick_capture(8'h96);
        repeat (4) tick();
        rst_n = 0;
        #1;
        chk("mid_rst_en", {31'b0, enc_en}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_no_done", {30'b0, frame_done, err_timeout}, 0);
        tick();
        rst_n = 1;
        send(8'h0F, 2'b01);
        quick_capture(8'hE1);
        wait_end(40, r);
        chk("post_rst_done", r, 1);
        chk("post_rst_sys", sys_col, 8'h0F);
        chk("post_rst_il", il_col, 8'hE1);
        chk("post_rst_sel", il_sel, 2'b01);
        // back-to-back with in_valid held
        tick();
        in_valid = 1;
        in_data = 8'h11;
        in_sel = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        tick();
        in_data = 8'h22;
        in_sel = 2'b10;
        quick_capture(8'h5A);
        wait_end(40, r);
        chk("b2b_done1", r, 1);
        chk("b2b_sys1", sys_col, 8'h11);
        @(negedge clk);
        chk("b2b_gap_ready", {31'b0, in_ready}, 1);
        chk("b2b_gap_sel", il_sel, 2'b00);
        @(negedge clk);
        chk("b2b_xfer_busy", {31'b0, busy}, 1);
        chk("b2b_xfer_sel", il_sel, 2'b10);
        chk("b2b_xfer_data", il_data, 8'h22);
        in_valid = 0;
        tick();
        quick_capture(8'hA0);
        wait_end(40, r);
        chk("b2b_done2", r, 1);
        chk("b2b_sys2", sys_col, 8'h22);
        // randomized traffic
        rm = 2;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c % 150 == 0) rm = $urandom_range(0, 5);
            if (rst_n == 0) rst_n = 1;
            else if ($urandom_range(0, 499) == 0) rst_n = 0;
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = 8'($urandom);
            in_sel = 2'($urandom);
            il_out = 8'($urandom);
            il_bit_start = (rm == 0) ? 1'b1 : (rm == 1) ? 1'b0 : ($urandom_range(0, 9) < 3);
        end
        tick();
        rst_n = 1;
        in_valid = 0;
        il_bit_start = 0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
